// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the LC-3 memory/IO controller: FSM state encoding,
// the default memory-mapped IO address and the SRAM bus widths.
package slc3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_WAIT,
        WR_DONE,
        IO_DONE
    } state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int unsigned SRAM_AW         = 20;
    localparam int unsigned SRAM_DW         = 16;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side memory bus: level request plus address/data, answered by a
// one-cycle MEM_RDY pulse with read data on MDR_in.
interface mem_io_ctrl_if;

    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MAR;
    logic [15:0] MDR_out;
    logic [15:0] MDR_in;
    logic        MEM_RDY;

    modport master (
        output MEM_REQ, MEM_WE, MAR, MDR_out,
        input  MDR_in, MEM_RDY
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MAR, MDR_out,
        output MDR_in, MEM_RDY
    );

endinterface

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous board switches into the
// system clock domain.
module sync2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Sequences CPU requests onto an asynchronous SRAM with fixed strobe timing,
// and serves one memory-mapped address from the switches / to the hex display.
module mem_io_ctrl
    import slc3_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_io_ctrl_if.slave       bus,
    input  logic [15:0]        S,
    output logic [15:0]        Hex_data,
    output logic [SRAM_AW-1:0] A,
    inout  wire  [SRAM_DW-1:0] Data,
    output logic               CE,
    output logic               UB,
    output logic               LB,
    output logic               OE,
    output logic               WE
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mdr_in_q, mdr_in_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] s_sync;
    logic        drive;
    logic        rdy;

    sync2 #(.WIDTH(16)) u_sync_s (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .d_i    (S),
        .q_o    (s_sync)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mar_q    <= '0;
            wdata_q  <= '0;
            mdr_in_q <= '0;
            hex_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mar_q    <= mar_d;
            wdata_q  <= wdata_d;
            mdr_in_q <= mdr_in_d;
            hex_q    <= hex_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mar_d    = mar_q;
        wdata_d  = wdata_q;
        mdr_in_d = mdr_in_q;
        hex_d    = hex_q;
        CE       = 1'b1;
        UB       = 1'b1;
        LB       = 1'b1;
        OE       = 1'b1;
        WE       = 1'b1;
        drive    = 1'b0;
        rdy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.MEM_REQ) begin
                    mar_d   = bus.MAR;
                    wdata_d = bus.MDR_out;
                    // IO transfers update their register on entry so the value
                    // is already valid while MEM_RDY is high in IO_DONE.
                    if (bus.MAR == IO_ADDR) begin
                        state_d = IO_DONE;
                        if (bus.MEM_WE) hex_d    = bus.MDR_out;
                        else            mdr_in_d = s_sync;
                    end else if (!bus.MEM_WE) begin
                        state_d = RD_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = WR_SETUP;
                    end
                end
            end
            RD_WAIT: begin
                CE = 1'b0;
                UB = 1'b0;
                LB = 1'b0;
                OE = 1'b0;
                if (cnt_q == '0) begin
                    mdr_in_d = Data;
                    state_d  = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DONE: begin
                rdy     = 1'b1;
                state_d = IDLE;
            end
            WR_SETUP: begin
                CE      = 1'b0;
                UB      = 1'b0;
                LB      = 1'b0;
                drive   = 1'b1;
                cnt_d   = WAIT_LD;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                CE    = 1'b0;
                UB    = 1'b0;
                LB    = 1'b0;
                WE    = 1'b0;
                drive = 1'b1;
                if (cnt_q == '0) state_d = WR_DONE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            WR_DONE: begin
                CE      = 1'b0;
                UB      = 1'b0;
                LB      = 1'b0;
                drive   = 1'b1;
                rdy     = 1'b1;
                state_d = IDLE;
            end
            IO_DONE: begin
                rdy     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign A           = (state_q == IDLE) ? '0 : {4'h0, mar_q};
    assign Data        = drive ? wdata_q : 'z;
    assign bus.MDR_in  = mdr_in_q;
    assign bus.MEM_RDY = rdy;
    assign Hex_data    = hex_q;

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM strobe-active cycles per access; legal range 1..15.
REQ-002 Parameter IO_ADDR, default 16'hFFFF: memory-mapped switch/hex address.
REQ-003 Clk  in  1  single system clock, all state on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 MEM_REQ  in  1  CPU access request, level; sampled only in IDLE.
REQ-006 MEM_WE  in  1  1 = write, 0 = read; sampled with MEM_REQ.
REQ-007 MAR  in  16  CPU address.
REQ-008 MDR_out  in  16  CPU write data.
REQ-009 MDR_in  out  16  read data returned to CPU.
REQ-010 MEM_RDY  out  1  one-cycle completion pulse.
REQ-011 S  in  16  board switches, asynchronous.
REQ-012 Hex_data  out  16  value shown on the four hex digits.
REQ-013 A  out  20  SRAM address.
REQ-014 Data  inout  16  SRAM data bus.
REQ-015 CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.

Function
REQ-016 FSM states: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_WAIT, WR_DONE, IO_DONE.
REQ-017 IDLE with MEM_REQ=1: latch MAR, MDR_out, MEM_WE; MAR==IO_ADDR -> IO_DONE; else MEM_WE=0 -> RD_WAIT; else WR_SETUP.
REQ-018 A = {4'h0, latched MAR} from the cycle after acceptance until return to IDLE.
REQ-019 RD_WAIT: CE=OE=UB=LB=0, WE=1, Data tri-stated, held exactly WAIT_CYCLES cycles by a down-counter.
REQ-020 Last RD_WAIT cycle: Data captured into MDR_in; -> RD_DONE.
REQ-021 WR_SETUP (1 cycle): Data driven with latched MDR_out, CE=UB=LB=0, WE=OE=1.
REQ-022 WR_WAIT: WE=0, Data still driven, held WAIT_CYCLES cycles; -> WR_DONE.
REQ-023 WR_DONE: WE=1, Data still driven (hold); MEM_RDY=1; -> IDLE.
REQ-024 RD_DONE: strobes high, MEM_RDY=1; -> IDLE.
REQ-025 IO_DONE read: MDR_in <= synchronized S; write: Hex_data <= latched MDR_out; no SRAM strobe asserted; MEM_RDY=1; -> IDLE.
REQ-026 Latency acceptance-to-MEM_RDY: read WAIT_CYCLES+1, write WAIT_CYCLES+2, IO 1 cycle.
REQ-027 Data driven only in WR_SETUP, WR_WAIT, WR_DONE; high-Z otherwise.
REQ-028 MEM_REQ still high in the cycle after MEM_RDY starts a new access (back-to-back allowed, one IDLE cycle minimum).
REQ-029 MAR/MDR_out/MEM_WE changes during an access are ignored.
REQ-030 S passes a two-flop synchronizer before use.
REQ-031 MDR_in and Hex_data hold value between updates.

Reset
REQ-032 Reset=0 forces, asynchronously: state IDLE, CE=UB=LB=OE=WE=1, Data high-Z, A=0, MDR_in=0, Hex_data=0, MEM_RDY=0, counter 0, synchronizer 0.
REQ-033 Reset mid-access aborts immediately with no MEM_RDY; Hex_data/SRAM not written if WR_WAIT not reached.

Structure
REQ-034 Shared package slc3_pkg holds the state enum, IO_ADDR default and SRAM width constants.
REQ-035 One sub-module: sync2 (two-flop synchronizer, 16 wide) for S.

Verification
REQ-036 Read 0x005A, SRAM holds 16'h1234, WAIT_CYCLES=2 -> OE/CE low 2 cycles, MEM_RDY 3 cycles after acceptance, MDR_in=16'h1234.
REQ-037 Write 16'hBEEF to 0x0031 -> WE low exactly 2 cycles, Data=BEEF WR_SETUP..WR_DONE, readback returns BEEF.
REQ-038 S=16'h0606, read IO_ADDR -> MDR_in=16'h0606, MEM_RDY 1 cycle later, all strobes high.
REQ-039 Write 16'h00AB to IO_ADDR -> Hex_data=16'h00AB, WE never low.
REQ-040 Reset low during RD_WAIT -> strobes high and Data high-Z same edge, no MEM_RDY, outputs at reset values.
REQ-041 MEM_REQ held high with alternating read/write -> each access completes with one MEM_RDY, one IDLE cycle between.
